// File: rtl/fetch_queue_if.sv
// Decoder-side handshake of the fetch queue: head entry plus valid/ready.
interface fetch_queue_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32
);
    logic                  id_valid;
    logic                  id_ready;
    logic [INST_WIDTH-1:0] id_inst;
    logic [ADDR_WIDTH-1:0] id_cur_pc;
    logic [ADDR_WIDTH-1:0] id_mis_pc;
    logic                  id_pd_tk;

    // Fetch side presents the head entry
    modport master (
        output id_valid,
        output id_inst,
        output id_cur_pc,
        output id_mis_pc,
        output id_pd_tk,
        input  id_ready
    );

    // Decoder side consumes the head entry
    modport slave (
        input  id_valid,
        input  id_inst,
        input  id_cur_pc,
        input  id_mis_pc,
        input  id_pd_tk,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: walks the PC through icache and branch predictor
// and buffers hits, with their prediction metadata, in a circular queue that
// the decoder drains over a valid/ready handshake. A ROB rollback empties the
// queue and redirects the PC in one cycle.
module fetch_queue #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter int unsigned           IQ_DEPTH   = 8,
    parameter int unsigned           PTR_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           PC_INC     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_rb,
    input  logic [ADDR_WIDTH-1:0] rob_rb_pc,
    output logic                  cache_rd_en,
    output logic [ADDR_WIDTH-1:0] cache_rd_addr,
    input  logic                  cache_hit,
    input  logic [INST_WIDTH-1:0] cache_hit_inst,
    output logic                  bp_ena,
    output logic [ADDR_WIDTH-1:0] bp_pb_pc,
    output logic [INST_WIDTH-1:0] bp_pb_inst,
    input  logic                  bp_pd_tk,
    input  logic [ADDR_WIDTH-1:0] bp_pd_off,
    fetch_queue_if.master         id,
    output logic [PTR_WIDTH:0]    iq_cnt
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [PTR_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]  tail;
    logic [PTR_WIDTH:0]    count;

    logic [INST_WIDTH-1:0] q_inst   [IQ_DEPTH];
    logic [ADDR_WIDTH-1:0] q_cur_pc [IQ_DEPTH];
    logic [ADDR_WIDTH-1:0] q_mis_pc [IQ_DEPTH];
    logic                  q_pd_tk  [IQ_DEPTH];

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] succ_pc;
    logic [ADDR_WIDTH-1:0] jump_pc;
    logic [ADDR_WIDTH-1:0] mis_pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [PTR_WIDTH:0]    count_nxt;

    // Fetch request, push/pop qualification and next-PC selection
    always_comb begin
        full        = (count == (PTR_WIDTH + 1)'(IQ_DEPTH));
        empty       = (count == '0);
        // A full queue does not fetch even when a pop frees a slot this cycle
        cache_rd_en = rdy & ~rst & ~if_rb & ~full;
        push        = cache_rd_en & cache_hit;
        pop         = ~empty & id.id_ready & rdy & ~if_rb & ~rst;
        succ_pc     = pc + ADDR_WIDTH'(PC_INC);
        jump_pc     = pc + bp_pd_off;
        mis_pc      = bp_pd_tk ? succ_pc : jump_pc;
        next_pc     = bp_pd_tk ? jump_pc : succ_pc;
        count_nxt   = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // PC, pointers and occupancy; reset beats freeze, freeze beats rollback
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (if_rb) begin
                pc    <= rob_rb_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    pc   <= next_pc;
                    tail <= tail + PTR_WIDTH'(1);
                end
                if (pop) begin
                    head <= head + PTR_WIDTH'(1);
                end
                count <= count_nxt;
            end
        end
    end

    // Entry storage; deliberately not cleared by reset or rollback
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail]   <= cache_hit_inst;
            q_cur_pc[tail] <= pc;
            q_mis_pc[tail] <= mis_pc;
            q_pd_tk[tail]  <= bp_pd_tk;
        end
    end

    // Head entry, icache and predictor probe outputs
    always_comb begin
        id.id_valid   = ~empty;
        id.id_inst    = q_inst[head];
        id.id_cur_pc  = q_cur_pc[head];
        id.id_mis_pc  = q_mis_pc[head];
        id.id_pd_tk   = q_pd_tk[head];
        cache_rd_addr = pc;
        bp_ena        = cache_rd_en;
        bp_pb_pc      = pc;
        bp_pb_inst    = cache_hit_inst;
        iq_cnt        = count;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a PC model plus a queue scoreboard of the
// entries the queue should hold, compared every cycle against the DUT.
module tb_fetch_queue;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] mis;
        logic        tk;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_rb;
    logic [31:0] rob_rb_pc;
    logic        cache_rd_en;
    logic [31:0] cache_rd_addr;
    logic        cache_hit;
    logic [31:0] cache_hit_inst;
    logic        bp_ena;
    logic [31:0] bp_pb_pc;
    logic [31:0] bp_pb_inst;
    logic        bp_pd_tk;
    logic [31:0] bp_pd_off;
    logic [3:0]  iq_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    entry_t      sb[$];
    logic [31:0] m_pc;

    fetch_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) idif ();

    fetch_queue #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .IQ_DEPTH  (8),
        .PTR_WIDTH (3),
        .RESET_PC  (32'h0),
        .PC_INC    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .if_rb         (if_rb),
        .rob_rb_pc     (rob_rb_pc),
        .cache_rd_en   (cache_rd_en),
        .cache_rd_addr (cache_rd_addr),
        .cache_hit     (cache_hit),
        .cache_hit_inst(cache_hit_inst),
        .bp_ena        (bp_ena),
        .bp_pb_pc      (bp_pb_pc),
        .bp_pb_inst    (bp_pb_inst),
        .bp_pd_tk      (bp_pd_tk),
        .bp_pd_off     (bp_pd_off),
        .id            (idif.master),
        .iq_cnt        (iq_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after negedge, check, advance the model.
    task automatic step(input logic hit, input logic tk, input logic [31:0] off,
                        input logic ready, input logic r, input logic rb,
                        input logic [31:0] rbpc);
        int unsigned sz;
        logic        exp_en;
        entry_t      e;
        cache_hit      = hit;
        bp_pd_tk       = tk;
        bp_pd_off      = off;
        idif.id_ready  = ready;
        rdy            = r;
        if_rb          = rb;
        rob_rb_pc      = rbpc;
        cache_hit_inst = m_pc ^ 32'hC0DE_0000;
        #1;
        sz     = sb.size();
        exp_en = r & ~rb & (sz != 8);
        chk("cache_rd_en", cache_rd_en, exp_en);
        chk("bp_ena", bp_ena, exp_en);
        chk("cache_rd_addr", cache_rd_addr, m_pc);
        chk("bp_pb_pc", bp_pb_pc, m_pc);
        chk("bp_pb_inst", bp_pb_inst, m_pc ^ 32'hC0DE_0000);
        chk("iq_cnt", iq_cnt, sz);
        chk("id_valid", idif.id_valid, sz != 0);
        if (sz != 0) begin
            chk("id_inst", idif.id_inst, sb[0].inst);
            chk("id_cur_pc", idif.id_cur_pc, sb[0].pc);
            chk("id_mis_pc", idif.id_mis_pc, sb[0].mis);
            chk("id_pd_tk", idif.id_pd_tk, sb[0].tk);
        end
        if (r) begin
            if (rb) begin
                sb.delete();
                m_pc = rbpc;
            end else begin
                if (sz != 0 && ready) void'(sb.pop_front());
                if (exp_en && hit) begin
                    e.inst = m_pc ^ 32'hC0DE_0000;
                    e.pc   = m_pc;
                    e.mis  = tk ? m_pc + 32'd4 : m_pc + off;
                    e.tk   = tk;
                    sb.push_back(e);
                    m_pc   = tk ? m_pc + off : m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; if_rb = 1'b0; rob_rb_pc = '0;
        cache_hit = 1'b0; cache_hit_inst = '0; bp_pd_tk = 1'b0; bp_pd_off = '0;
        idif.id_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_rd_en", cache_rd_en, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        m_pc = 32'h0;
        sb.delete();
        #1;
        chk("rst_iq_cnt", iq_cnt, 4'd0);
        chk("rst_id_valid", idif.id_valid, 1'b0);
        chk("rst_pc", cache_rd_addr, 32'h0);
        @(negedge clk);

        // Sequential fetch 0x0, 0x4, then two misses at 0x8, then hits
        step(1, 0, 32'h40, 1, 1, 0, 0);
        step(1, 0, 32'h40, 1, 1, 0, 0);
        step(0, 0, 32'h40, 1, 1, 0, 0);
        step(0, 0, 32'h40, 1, 1, 0, 0);
        step(1, 0, 32'h40, 1, 1, 0, 0);
        step(1, 0, 32'h40, 1, 1, 0, 0);
        // Taken prediction at 0x10 with offset 0x20: next fetch 0x30
        step(1, 1, 32'h20, 1, 1, 0, 0);
        step(1, 0, 32'h40, 1, 1, 0, 0);
        chk("taken_target", m_pc, 32'h34);

        // Fill to full with decoder stalled, one pop, refill, drain across wrap
        for (int i = 0; i < 10; i++) step(1, 0, 32'h8, 0, 1, 0, 0);
        chk("full_cnt", iq_cnt, 4'd8);
        step(1, 0, 32'h8, 1, 1, 0, 0);
        step(1, 0, 32'h8, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 32'h8, 1, 1, 0, 0);

        // Freeze with rdy low mid-stream
        step(1, 0, 32'h10, 1, 1, 0, 0);
        step(1, 0, 32'h10, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 32'h10, 1, 0, 0, 0);
        step(1, 0, 32'h10, 1, 1, 0, 0);
        step(1, 0, 32'h10, 1, 1, 0, 0);
        step(0, 0, 32'h10, 1, 1, 0, 0);

        // Five entries buffered, then rollback with a same-cycle hit and pop
        for (int i = 0; i < 5; i++) step(1, 0, 32'h4, 0, 1, 0, 0);
        chk("pre_rb_cnt", iq_cnt, 4'd5);
        step(1, 0, 32'h4, 1, 1, 1, 32'h100);
        step(1, 0, 32'h4, 1, 1, 0, 0);
        step(1, 0, 32'h4, 1, 1, 0, 0);
        step(0, 0, 32'h4, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
